pcie_host_wr_desc_dispatch: RTL and testbench

//  Upstream stage of the PCIe continuous-write (core-to-host) path. Buffers host write descriptors,

---
 rtl/pcie_host_wr_desc_dispatch.sv | 197 +++++++++++++++++++
 tb/tb_pcie_host_wr_desc_dispatch.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_host_wr_desc_dispatch.sv
// Host write-descriptor front end: validates descriptors, queues good ones, meters them to the
// write controller under an outstanding-request limit, and merges completion/error status.
module pcie_host_wr_desc_dispatch #(
  parameter int HOST_DMA_TAG_WIDTH  = 32,
  parameter int PCIE_ADDR_WIDTH     = 64,
  parameter int PCIE_RAM_ADDR_WIDTH = 32,
  parameter int PCIE_DMA_LEN_WIDTH  = 16,
  parameter int MAX_LEN             = 2048,
  parameter int CORE_COUNT          = 16,
  parameter int CORE_WIDTH          = $clog2(CORE_COUNT),
  parameter int CORE_ADDR_WIDTH     = 16,
  parameter int FIFO_DEPTH          = 8,
  parameter int MAX_OUTSTANDING     = 16
) (
  input  logic                                   pcie_clk,
  input  logic                                   pcie_rst_n,
  input  logic                                   enable,

  input  logic [PCIE_ADDR_WIDTH-1:0]             s_desc_pcie_addr,
  input  logic [PCIE_RAM_ADDR_WIDTH-1:0]         s_desc_ram_addr,
  input  logic [PCIE_DMA_LEN_WIDTH-1:0]          s_desc_len,
  input  logic [HOST_DMA_TAG_WIDTH-1:0]          s_desc_tag,
  input  logic                                   s_desc_valid,
  output logic                                   s_desc_ready,

  output logic [PCIE_ADDR_WIDTH-1:0]             m_desc_pcie_addr,
  output logic [PCIE_RAM_ADDR_WIDTH-1:0]         m_desc_ram_addr,
  output logic [PCIE_DMA_LEN_WIDTH-1:0]          m_desc_len,
  output logic [HOST_DMA_TAG_WIDTH-1:0]          m_desc_tag,
  output logic                                   m_desc_valid,
  input  logic                                   m_desc_ready,

  input  logic [HOST_DMA_TAG_WIDTH-1:0]          m_status_tag,
  input  logic                                   m_status_valid,

  output logic [HOST_DMA_TAG_WIDTH-1:0]          s_status_tag,
  output logic                                   s_status_error,
  output logic                                   s_status_valid,

  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_count
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [PCIE_ADDR_WIDTH-1:0]     pcie_addr;
    logic [PCIE_RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [PCIE_DMA_LEN_WIDTH-1:0]  len;
    logic [HOST_DMA_TAG_WIDTH-1:0]  tag;
  } desc_t;

  desc_t                         in_desc;
  desc_t                         head_desc;
  desc_t                         out_desc;
  desc_t                         fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]                wr_ptr;
  logic [PTR_W:0]                rd_ptr;
  logic                          fifo_empty;
  logic                          fifo_full;

  logic [CORE_WIDTH-1:0]         dest_core;
  logic                          desc_bad;
  logic                          in_hs;
  logic                          in_good;
  logic                          out_hs;
  logic                          head_avail;
  logic                          load;
  logic                          push;
  logic                          pop;

  logic [CNT_W-1:0]              count;
  logic [CNT_W-1:0]              count_next;
  logic                          err_pend;
  logic [HOST_DMA_TAG_WIDTH-1:0] err_tag;

  always_comb begin
    in_desc.pcie_addr = s_desc_pcie_addr;
    in_desc.ram_addr  = s_desc_ram_addr;
    in_desc.len       = s_desc_len;
    in_desc.tag       = s_desc_tag;
  end

  assign dest_core = s_desc_ram_addr[CORE_ADDR_WIDTH +: CORE_WIDTH];

  always_comb begin
    desc_bad = (s_desc_len == '0)
            || (int'(s_desc_len) > MAX_LEN)
            || (int'(dest_core) >= CORE_COUNT);
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W])
                   && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // Ready comes only from registered state so it never depends on s_desc_valid.
  assign s_desc_ready = !fifo_full && !err_pend;
  assign in_hs        = s_desc_valid && s_desc_ready;
  assign in_good      = in_hs && !desc_bad;
  assign out_hs       = m_desc_valid && m_desc_ready;

  always_comb begin
    count_next = count;
    if (out_hs && !m_status_valid) begin
      count_next = count + CNT_W'(1);
    end else if (!out_hs && m_status_valid && (count != '0)) begin
      count_next = count - CNT_W'(1);
    end
  end

  // An empty FIFO lets an accepted descriptor bypass straight into the output register,
  // giving one-cycle latency; ordering holds because bypass only happens when nothing is queued.
  assign head_desc  = fifo_empty ? in_desc : fifo_mem[rd_ptr[PTR_W-1:0]];
  assign head_avail = !fifo_empty || in_good;

  // count_next already includes this cycle's handshake, so count plus the held slot never
  // exceeds the limit.
  assign load = (!m_desc_valid || m_desc_ready) && head_avail && enable
             && (int'(count_next) < MAX_OUTSTANDING);
  assign push = in_good && !(load && fifo_empty);
  assign pop  = load && !fifo_empty;

  always_ff @(posedge pcie_clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= in_desc;
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      m_desc_valid <= 1'b0;
      out_desc     <= '0;
    end else if (load) begin
      m_desc_valid <= 1'b1;
      out_desc     <= head_desc;
    end else if (out_hs) begin
      m_desc_valid <= 1'b0;
    end
  end

  assign m_desc_pcie_addr = out_desc.pcie_addr;
  assign m_desc_ram_addr  = out_desc.ram_addr;
  assign m_desc_len       = out_desc.len;
  assign m_desc_tag       = out_desc.tag;

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign outstanding_count = count;

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      err_pend <= 1'b0;
      err_tag  <= '0;
    end else if (in_hs && desc_bad) begin
      err_pend <= 1'b1;
      err_tag  <= s_desc_tag;
    end else if (err_pend && !m_status_valid) begin
      err_pend <= 1'b0;
    end
  end

  // Completions take priority; a pending error waits until a cycle with no completion.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      s_status_valid <= 1'b0;
      s_status_error <= 1'b0;
      s_status_tag   <= '0;
    end else if (m_status_valid) begin
      s_status_valid <= 1'b1;
      s_status_error <= 1'b0;
      s_status_tag   <= m_status_tag;
    end else if (err_pend) begin
      s_status_valid <= 1'b1;
      s_status_error <= 1'b1;
      s_status_tag   <= err_tag;
    end else begin
      s_status_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcie_host_wr_desc_dispatch.sv
// Self-checking bench for pcie_host_wr_desc_dispatch: vector table, directed corner sequences
// and a randomized run against a queue-based transaction model.
module tb_pcie_host_wr_desc_dispatch;

  localparam int TW = 32;
  localparam int AW = 64;
  localparam int RW = 32;
  localparam int LW = 16;
  localparam int MAXLEN = 2048;
  localparam int CC = 12;
  localparam int MO = 2;
  localparam int NW = $clog2(MO + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] s_desc_pcie_addr = '0;
  logic [RW-1:0] s_desc_ram_addr = '0;
  logic [LW-1:0] s_desc_len = '0;
  logic [TW-1:0] s_desc_tag = '0;
  logic          s_desc_valid = 1'b0;
  logic          s_desc_ready;
  logic [AW-1:0] m_desc_pcie_addr;
  logic [RW-1:0] m_desc_ram_addr;
  logic [LW-1:0] m_desc_len;
  logic [TW-1:0] m_desc_tag;
  logic          m_desc_valid;
  logic          m_desc_ready = 1'b0;
  logic [TW-1:0] m_status_tag = '0;
  logic          m_status_valid = 1'b0;
  logic [TW-1:0] s_status_tag;
  logic          s_status_error;
  logic          s_status_valid;
  logic [NW-1:0] outstanding_count;

  always #5 clk = ~clk;

  pcie_host_wr_desc_dispatch #(
    .HOST_DMA_TAG_WIDTH (TW),
    .PCIE_ADDR_WIDTH    (AW),
    .PCIE_RAM_ADDR_WIDTH(RW),
    .PCIE_DMA_LEN_WIDTH (LW),
    .MAX_LEN            (MAXLEN),
    .CORE_COUNT         (CC),
    .CORE_ADDR_WIDTH    (16),
    .FIFO_DEPTH         (8),
    .MAX_OUTSTANDING    (MO)
  ) dut (
    .pcie_clk         (clk),
    .pcie_rst_n       (rst_n),
    .enable           (enable),
    .s_desc_pcie_addr (s_desc_pcie_addr),
    .s_desc_ram_addr  (s_desc_ram_addr),
    .s_desc_len       (s_desc_len),
    .s_desc_tag       (s_desc_tag),
    .s_desc_valid     (s_desc_valid),
    .s_desc_ready     (s_desc_ready),
    .m_desc_pcie_addr (m_desc_pcie_addr),
    .m_desc_ram_addr  (m_desc_ram_addr),
    .m_desc_len       (m_desc_len),
    .m_desc_tag       (m_desc_tag),
    .m_desc_valid     (m_desc_valid),
    .m_desc_ready     (m_desc_ready),
    .m_status_tag     (m_status_tag),
    .m_status_valid   (m_status_valid),
    .s_status_tag     (s_status_tag),
    .s_status_error   (s_status_error),
    .s_status_valid   (s_status_valid),
    .outstanding_count(outstanding_count)
  );

  typedef struct {
    logic [LW-1:0] len;
    int            core;
    logic [TW-1:0] tag;
    logic          bad;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] pa;
    logic [RW-1:0] ra;
    logic [LW-1:0] len;
    logic [TW-1:0] tag;
  } d_t;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [TW-1:0] issued_q[$];
  logic [TW-1:0] cmp_q[$];
  int            acc_n = 0;
  logic          auto_cmp = 1'b0;

  d_t            exp_good[$];
  logic [TW-1:0] exp_bad[$];
  logic [TW-1:0] pend_q[$];
  int            mcnt;
  logic          stall;
  d_t            stall_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (s_desc_valid && s_desc_ready) acc_n++;
    if (m_desc_valid && m_desc_ready) begin
      issued_q.push_back(m_desc_tag);
      cmp_q.push_back(m_desc_tag);
    end
    @(posedge clk);
    #1;
    if (auto_cmp) begin
      if (cmp_q.size() > 0) begin
        m_status_valid = 1'b1;
        m_status_tag   = cmp_q.pop_front();
      end else begin
        m_status_valid = 1'b0;
      end
    end
  endtask

  task automatic set_desc(input logic [LW-1:0] len, input int core, input logic [TW-1:0] tag);
    s_desc_len       = len;
    s_desc_tag       = tag;
    s_desc_pcie_addr = {tag, ~tag};
    s_desc_ram_addr  = {12'h0, 4'(core), tag[15:0]};
  endtask

  task automatic send_good(input logic [TW-1:0] tag);
    set_desc(LW'(64), 1, tag);
    s_desc_valid = 1'b1;
    tick();
    s_desc_valid = 1'b0;
  endtask

  task automatic complete(input logic [TW-1:0] tag);
    m_status_valid = 1'b1;
    m_status_tag   = tag;
    tick();
    m_status_valid = 1'b0;
  endtask

  vec_t vt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [TW-1:0] t;
    logic accepted;
    int   waited;
    logic hs_in, hs_out, cmp, bad;
    logic [TW-1:0] cmp_tag;
    d_t   e;
    d_t   cur;

    // ---- reset state ----
    #2;
    chk("rst_m_valid", m_desc_valid, 0);
    chk("rst_s_status_valid", s_status_valid, 0);
    chk("rst_s_status_error", s_status_error, 0);
    chk("rst_s_status_tag", s_status_tag, 0);
    chk("rst_count", outstanding_count, 0);
    chk("rst_m_tag", m_desc_tag, 0);
    chk("rst_m_addr", m_desc_pcie_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", s_desc_ready, 1);

    // ---- vector table ----
    vt[0] = '{LW'(64),    3,  32'hA5, 1'b0};
    vt[1] = '{LW'(0),     0,  32'h01, 1'b1};
    vt[2] = '{LW'(2049),  0,  32'h02, 1'b1};
    vt[3] = '{LW'(2048),  11, 32'h03, 1'b0};
    vt[4] = '{LW'(1),     0,  32'h04, 1'b0};
    vt[5] = '{16'hFFFF,   2,  32'h05, 1'b1};
    vt[6] = '{LW'(100),   12, 32'h06, 1'b1};
    vt[7] = '{LW'(100),   15, 32'h07, 1'b1};
    vt[8] = '{LW'(2047),  5,  32'h08, 1'b0};
    vt[9] = '{LW'(512),   11, 32'hDEADBEEF, 1'b0};

    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_desc(vt[i].len, vt[i].core, vt[i].tag);
      chk("vec_ready", s_desc_ready, 1);
      s_desc_valid = 1'b1;
      tick();
      s_desc_valid = 1'b0;
      if (!vt[i].bad) begin
        chk("vec_m_valid", m_desc_valid, 1);
        chk("vec_m_pcie_addr", m_desc_pcie_addr, {vt[i].tag, ~vt[i].tag});
        chk("vec_m_ram_addr", m_desc_ram_addr, {12'h0, 4'(vt[i].core), vt[i].tag[15:0]});
        chk("vec_m_len", m_desc_len, vt[i].len);
        chk("vec_m_tag", m_desc_tag, vt[i].tag);
        m_desc_ready = 1'b1;
        tick();
        m_desc_ready = 1'b0;
        chk("vec_m_valid_drop", m_desc_valid, 0);
        chk("vec_count_1", outstanding_count, 1);
        complete(vt[i].tag);
        chk("vec_st_valid", s_status_valid, 1);
        chk("vec_st_error", s_status_error, 0);
        chk("vec_st_tag", s_status_tag, vt[i].tag);
        chk("vec_count_0", outstanding_count, 0);
      end else begin
        chk("vec_bad_no_issue", m_desc_valid, 0);
        chk("vec_bad_ready_low", s_desc_ready, 0);
        tick();
        chk("vec_err_valid", s_status_valid, 1);
        chk("vec_err_error", s_status_error, 1);
        chk("vec_err_tag", s_status_tag, vt[i].tag);
        chk("vec_err_count", outstanding_count, 0);
        chk("vec_err_ready_back", s_desc_ready, 1);
      end
      tick();
      chk("vec_st_idle", s_status_valid, 0);
    end

    // ---- outstanding limit ----
    issued_q.delete();
    m_desc_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_good(32'h40 + i);
    repeat (6) tick();
    chk("lim_issued_2", issued_q.size(), 2);
    chk("lim_count_2", outstanding_count, 2);
    chk("lim_m_valid_0", m_desc_valid, 0);
    complete(32'h40);
    repeat (4) tick();
    chk("lim_issued_3", issued_q.size(), 3);
    chk("lim_count_still_2", outstanding_count, 2);
    complete(32'h41);
    repeat (4) tick();
    chk("lim_issued_4", issued_q.size(), 4);
    for (int i = 0; i < 4 && i < issued_q.size(); i++) begin
      t = issued_q[i];
      chk("lim_order", t, 32'h40 + i);
    end
    complete(32'h42);
    complete(32'h43);
    tick();
    chk("lim_count_0", outstanding_count, 0);

    // ---- FIFO full: 9 offered with issue blocked ----
    enable = 1'b0;
    m_desc_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 9; i++) begin
      set_desc(LW'(128), 2, 32'h80 + i);
      s_desc_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
        accepted = s_desc_ready;
        tick();
        if (accepted) break;
      end
    end
    chk("full_accepted_8", acc_n, 8);
    chk("full_ready_low", s_desc_ready, 0);
    chk("full_no_issue", m_desc_valid, 0);
    issued_q.delete();
    cmp_q.delete();
    enable = 1'b1;
    m_desc_ready = 1'b1;
    chk("full_push_waits", s_desc_ready, 0);
    auto_cmp = 1'b1;
    tick();
    chk("full_ready_after_pop", s_desc_ready, 1);
    tick();
    s_desc_valid = 1'b0;
    chk("full_accepted_9", acc_n, 9);
    waited = 0;
    while ((issued_q.size() < 9 || outstanding_count != 0) && waited < 80) begin
      tick();
      waited++;
    end
    chk("full_drain_in_time", waited < 80, 1);
    for (int i = 0; i < 9 && i < issued_q.size(); i++) begin
      t = issued_q[i];
      chk("full_order", t, 32'h80 + i);
    end
    tick();
    auto_cmp = 1'b0;
    m_status_valid = 1'b0;
    repeat (2) tick();
    chk("full_count_0", outstanding_count, 0);

    // ---- bad descriptor colliding with a completion ----
    send_good(32'h55);
    tick();
    m_desc_ready = 1'b0;
    chk("coll_count_1", outstanding_count, 1);
    set_desc(LW'(0), 0, 32'h77);
    s_desc_valid = 1'b1;
    m_status_valid = 1'b1;
    m_status_tag = 32'h55;
    tick();
    s_desc_valid = 1'b0;
    m_status_valid = 1'b0;
    chk("coll_cmp_valid", s_status_valid, 1);
    chk("coll_cmp_error", s_status_error, 0);
    chk("coll_cmp_tag", s_status_tag, 32'h55);
    chk("coll_count_0", outstanding_count, 0);
    tick();
    chk("coll_err_valid", s_status_valid, 1);
    chk("coll_err_error", s_status_error, 1);
    chk("coll_err_tag", s_status_tag, 32'h77);
    tick();
    chk("coll_idle", s_status_valid, 0);

    // ---- spurious completion at zero ----
    complete(32'h99);
    chk("spur_valid", s_status_valid, 1);
    chk("spur_tag", s_status_tag, 32'h99);
    chk("spur_count", outstanding_count, 0);
    tick();

    // ---- enable gating ----
    issued_q.delete();
    enable = 1'b0;
    m_desc_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_good(32'h61 + i);
    repeat (3) tick();
    chk("en_hold_off", m_desc_valid, 0);
    chk("en_none_issued", issued_q.size(), 0);
    enable = 1'b1;
    tick();
    chk("en_first_valid", m_desc_valid, 1);
    chk("en_first_tag", m_desc_tag, 32'h61);
    tick();
    chk("en_second_valid", m_desc_valid, 1);
    chk("en_second_tag", m_desc_tag, 32'h62);
    chk("en_count_1", outstanding_count, 1);
    tick();
    chk("en_limit_stop", m_desc_valid, 0);
    chk("en_count_2", outstanding_count, 2);
    complete(32'h61);
    chk("en_third_tag", m_desc_tag, 32'h63);
    chk("en_third_valid", m_desc_valid, 1);
    tick();
    complete(32'h62);
    complete(32'h63);
    tick();
    chk("en_count_0", outstanding_count, 0);

    // ---- held output survives enable drop ----
    m_desc_ready = 1'b0;
    send_good(32'h70);
    chk("hold_valid", m_desc_valid, 1);
    enable = 1'b0;
    repeat (2) tick();
    chk("hold_still_valid", m_desc_valid, 1);
    chk("hold_tag", m_desc_tag, 32'h70);
    m_desc_ready = 1'b1;
    tick();
    m_desc_ready = 1'b0;
    complete(32'h70);
    tick();

    // ---- reset mid-burst ----
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_desc(LW'(32), 4, 32'hB0 + i);
      s_desc_valid = 1'b1;
      if (i == 2) begin
        m_status_valid = 1'b1;
        m_status_tag = 32'hEE;
      end
      tick();
    end
    m_status_valid = 1'b0;
    chk("mid_pre_m_valid", m_desc_valid, 1);
    chk("mid_pre_st_valid", s_status_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_m_valid", m_desc_valid, 0);
    chk("mid_st_valid", s_status_valid, 0);
    chk("mid_count", outstanding_count, 0);
    chk("mid_st_tag", s_status_tag, 0);
    chk("mid_m_tag", m_desc_tag, 0);
    s_desc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_ready_after", s_desc_ready, 1);
    chk("mid_fifo_emptied", m_desc_valid, 0);

    // ---- randomized run against transaction model ----
    mcnt = 0;
    stall = 1'b0;
    stall_d = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      hs_in   = s_desc_valid && s_desc_ready;
      hs_out  = m_desc_valid && m_desc_ready;
      cmp     = m_status_valid;
      cmp_tag = m_status_tag;
      cur     = '{m_desc_pcie_addr, m_desc_ram_addr, m_desc_len, m_desc_tag};
      if (stall) begin
        chk("rnd_hold_valid", m_desc_valid, 1);
        chk("rnd_hold_data", cur[63:0] ^ cur[127:64], stall_d[63:0] ^ stall_d[127:64]);
      end
      stall   = m_desc_valid && !m_desc_ready;
      stall_d = cur;
      if (hs_in) begin
        bad = (s_desc_len == 0) || (s_desc_len > LW'(MAXLEN)) || (s_desc_ram_addr[19:16] >= 4'(CC));
        if (bad) exp_bad.push_back(s_desc_tag);
        else exp_good.push_back('{s_desc_pcie_addr, s_desc_ram_addr, s_desc_len, s_desc_tag});
      end
      if (hs_out) begin
        if (exp_good.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd_unexpected_issue: got tag 0x%0h expected none", m_desc_tag);
        end else begin
          e = exp_good.pop_front();
          chk("rnd_issue_tag", m_desc_tag, e.tag);
          chk("rnd_issue_pa", m_desc_pcie_addr, e.pa);
          chk("rnd_issue_ra", m_desc_ram_addr, e.ra);
          chk("rnd_issue_len", m_desc_len, e.len);
        end
        pend_q.push_back(m_desc_tag);
      end
      if (hs_out && !cmp) mcnt++;
      else if (!hs_out && cmp && mcnt > 0) mcnt--;

      @(posedge clk);
      #1;
      chk("rnd_count", outstanding_count, mcnt);
      if (cmp) begin
        chk("rnd_cmp_valid", s_status_valid, 1);
        chk("rnd_cmp_error", s_status_error, 0);
        chk("rnd_cmp_tag", s_status_tag, cmp_tag);
      end else if (s_status_valid) begin
        chk("rnd_err_flag", s_status_error, 1);
        if (exp_bad.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd_unexpected_status: got tag 0x%0h expected none", s_status_tag);
        end else begin
          t = exp_bad.pop_front();
          chk("rnd_err_tag", s_status_tag, t);
        end
      end

      if (hs_in || !s_desc_valid) begin
        if (cyc < 1400 && $urandom_range(0, 9) < 6) begin
          case ($urandom_range(0, 9))
            0:       s_desc_len = '0;
            1:       s_desc_len = LW'($urandom_range(2049, 65535));
            2:       s_desc_len = LW'(2048);
            default: s_desc_len = LW'($urandom_range(1, 2048));
          endcase
          s_desc_tag       = $urandom;
          s_desc_pcie_addr = {$urandom, $urandom};
          s_desc_ram_addr  = $urandom;
          s_desc_ram_addr[19:16] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                                                : 4'($urandom_range(0, 11));
          s_desc_valid = 1'b1;
        end else begin
          s_desc_valid = 1'b0;
        end
      end
      m_desc_ready = ($urandom_range(0, 3) != 0);
      enable = (cyc >= 1400) || ($urandom_range(0, 7) != 0);
      if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        m_status_valid = 1'b1;
        m_status_tag   = pend_q.pop_front();
      end else begin
        m_status_valid = 1'b0;
      end
    end
    chk("rnd_all_issued", exp_good.size(), 0);
    chk("rnd_all_errors", exp_bad.size(), 0);
    chk("rnd_all_completed", pend_q.size(), 0);
    chk("rnd_final_count", outstanding_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
